// File: rtl/spi_opb_pkg.sv
// Shared definitions for the SPI-to-OPB bridge: FSM encoding, default command
// codes and the bit numbers at which each frame field completes.
package spi_opb_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_ADDR,
      ST_DUMMY,
      ST_RDATA,
      ST_WDATA,
      ST_IGNORE
   } state_t;

   localparam logic [7:0] CMD_RD_DEF = 8'h03;
   localparam logic [7:0] CMD_WR_DEF = 8'h02;

   // 1-based number of the last bit of each field within a frame
   localparam logic [6:0] BIT_CMD   = 7'd8;
   localparam logic [6:0] BIT_ADDR  = 7'd40;
   localparam logic [6:0] BIT_DUMMY = 7'd48;
   localparam logic [6:0] BIT_WDATA = 7'd72;
   localparam logic [6:0] BIT_RDATA = 7'd80;

endpackage

// File: rtl/spi_in_sync.sv
// Synchronisers for the asynchronous SPI pins plus single-cycle SCK/CS_N edge
// pulses derived from the synchronised levels.
module spi_in_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_sck,
   input  logic i_cs_n,
   input  logic i_mosi,
   output logic o_sck_rise,
   output logic o_sck_fall,
   output logic o_cs_fall,
   output logic o_cs_n,
   output logic o_mosi
);

   logic [SYNC_STAGES-1:0] r_sck_sync;
   logic [SYNC_STAGES-1:0] r_cs_sync;
   logic [SYNC_STAGES-1:0] r_mosi_sync;
   logic [SYNC_STAGES-1:0] r_vld;
   logic                   r_sck_prev;
   logic                   r_cs_prev;
   logic                   r_armed;
   logic                   w_sck_s;
   logic                   w_cs_s;

   assign w_sck_s = r_sck_sync[SYNC_STAGES-1];
   assign w_cs_s  = r_cs_sync[SYNC_STAGES-1];

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_sck_sync  <= '0;
         r_cs_sync   <= '1;
         r_mosi_sync <= '0;
         r_vld       <= '0;
         r_sck_prev  <= 1'b0;
         r_cs_prev   <= 1'b1;
         r_armed     <= 1'b0;
      end else begin
         r_sck_sync  <= (r_sck_sync << 1) | SYNC_STAGES'(i_sck);
         r_cs_sync   <= (r_cs_sync << 1) | SYNC_STAGES'(i_cs_n);
         r_mosi_sync <= (r_mosi_sync << 1) | SYNC_STAGES'(i_mosi);
         r_vld       <= (r_vld << 1) | SYNC_STAGES'(1'b1);
         r_sck_prev  <= w_sck_s;
         r_cs_prev   <= w_cs_s;
         // The reset-forced high level of CS_N is not a real one; only a CS_N
         // high seen through a fully flushed chain may precede a frame start.
         if (r_vld[SYNC_STAGES-1] && w_cs_s)
            r_armed <= 1'b1;
      end
   end

   assign o_sck_rise = w_sck_s & ~r_sck_prev;
   assign o_sck_fall = ~w_sck_s & r_sck_prev;
   assign o_cs_fall  = r_armed & r_cs_prev & ~w_cs_s;
   assign o_cs_n     = w_cs_s;
   assign o_mosi     = r_mosi_sync[SYNC_STAGES-1];

endmodule

// File: rtl/spi_opb_bridge.sv
// SPI slave (mode 0) that turns read/write frames into single-cycle OPB
// decoder strobes, shifting read data back out on MISO.
//
// state     | meaning
// ST_IDLE   | waiting for CS_N falling edge
// ST_CMD    | shifting in the 8-bit command
// ST_ADDR   | shifting in the 32-bit address
// ST_DUMMY  | read: 8 dummy bits while decoder data is fetched
// ST_RDATA  | read: shifting 32 data bits out on MISO
// ST_WDATA  | write: shifting in 32 data bits
// ST_IGNORE | frame done or bad command, wait for CS_N high
module spi_opb_bridge
   import spi_opb_pkg::*;
#(
   parameter int         SYNC_STAGES = 2,
   parameter logic [7:0] CMD_RD      = CMD_RD_DEF,
   parameter logic [7:0] CMD_WR      = CMD_WR_DEF
) (
   input  logic        OPB_CLK,
   input  logic        OPB_RST,
   input  logic        SPI_SCK,
   input  logic        SPI_CS_N,
   input  logic        SPI_MOSI,
   output logic        SPI_MISO,
   output logic        SPI_MISO_OE,
   output logic        DEC_RE,
   output logic        DEC_WE,
   output logic [31:0] DEC_ADDR,
   output logic [31:0] DEC_DI,
   input  logic [31:0] DEC_DO,
   output logic        BUSY
);

   logic        w_sck_rise;
   logic        w_sck_fall;
   logic        w_cs_fall;
   logic        w_cs_n;
   logic        w_mosi;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [6:0]  r_bit_cnt;
   logic [6:0]  w_bit_num;
   logic [31:0] r_shift;
   logic [31:0] w_shift_nxt;
   logic        r_is_rd;
   logic [31:0] r_dec_addr;
   logic [31:0] r_dec_di;
   logic        r_dec_re;
   logic        r_dec_we;
   logic        r_re_d;
   logic [31:0] r_rdata;
   logic [31:0] r_miso_sr;
   logic        r_miso_oe;
   logic        w_sample;
   logic        w_cmd_load;
   logic        w_addr_load;
   logic        w_re_set;
   logic        w_we_set;

   spi_in_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .i_clk      (OPB_CLK),
      .i_rst      (OPB_RST),
      .i_sck      (SPI_SCK),
      .i_cs_n     (SPI_CS_N),
      .i_mosi     (SPI_MOSI),
      .o_sck_rise (w_sck_rise),
      .o_sck_fall (w_sck_fall),
      .o_cs_fall  (w_cs_fall),
      .o_cs_n     (w_cs_n),
      .o_mosi     (w_mosi)
   );

   assign w_bit_num   = r_bit_cnt + 7'd1;
   assign w_shift_nxt = {r_shift[30:0], w_mosi};
   assign w_sample    = w_sck_rise & ~w_cs_n &
                        (r_state != ST_IDLE) & (r_state != ST_IGNORE);

   always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
      if (OPB_RST) r_state <= ST_IDLE;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cmd_load  = 1'b0;
      w_addr_load = 1'b0;
      w_re_set    = 1'b0;
      w_we_set    = 1'b0;
      if (w_cs_n) begin
         w_state_nxt = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE:
               if (w_cs_fall) w_state_nxt = ST_CMD;
            ST_CMD:
               if (w_sck_rise && w_bit_num == BIT_CMD) begin
                  w_cmd_load = 1'b1;
                  if (w_shift_nxt[7:0] == CMD_RD || w_shift_nxt[7:0] == CMD_WR)
                     w_state_nxt = ST_ADDR;
                  else
                     w_state_nxt = ST_IGNORE;
               end
            ST_ADDR:
               if (w_sck_rise && w_bit_num == BIT_ADDR) begin
                  w_addr_load = 1'b1;
                  w_re_set    = r_is_rd;
                  w_state_nxt = r_is_rd ? ST_DUMMY : ST_WDATA;
               end
            ST_DUMMY:
               if (w_sck_rise && w_bit_num == BIT_DUMMY) w_state_nxt = ST_RDATA;
            ST_RDATA:
               if (w_sck_rise && w_bit_num == BIT_RDATA) w_state_nxt = ST_IGNORE;
            ST_WDATA:
               if (w_sck_rise && w_bit_num == BIT_WDATA) begin
                  w_we_set    = 1'b1;
                  w_state_nxt = ST_IGNORE;
               end
            default: w_state_nxt = r_state;
         endcase
      end
   end

   always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
      if (OPB_RST) begin
         r_bit_cnt  <= '0;
         r_shift    <= '0;
         r_is_rd    <= 1'b0;
         r_dec_addr <= '0;
         r_dec_di   <= '0;
         r_dec_re   <= 1'b0;
         r_dec_we   <= 1'b0;
         r_re_d     <= 1'b0;
         r_rdata    <= '0;
         r_miso_sr  <= '0;
         r_miso_oe  <= 1'b0;
      end else begin
         r_dec_re <= w_re_set;
         r_dec_we <= w_we_set;
         r_re_d   <= r_dec_re;
         if (r_state == ST_IDLE) r_bit_cnt <= '0;
         else if (w_sample)      r_bit_cnt <= w_bit_num;
         if (w_sample)    r_shift    <= w_shift_nxt;
         if (w_cmd_load)  r_is_rd    <= (w_shift_nxt[7:0] == CMD_RD);
         if (w_addr_load) r_dec_addr <= w_shift_nxt;
         if (w_we_set)    r_dec_di   <= w_shift_nxt;
         // decoder read data is valid the cycle after the DEC_RE cycle
         if (r_re_d)      r_rdata    <= DEC_DO;
         if (w_cs_n || (r_state == ST_RDATA && w_state_nxt == ST_IGNORE)) begin
            r_miso_oe <= 1'b0;
            r_miso_sr <= '0;
         end else if (r_state == ST_RDATA && w_sck_fall) begin
            if (!r_miso_oe) begin
               r_miso_oe <= 1'b1;
               r_miso_sr <= r_rdata;
            end else begin
               r_miso_sr <= r_miso_sr << 1;
            end
         end
      end
   end

   assign DEC_RE      = r_dec_re;
   assign DEC_WE      = r_dec_we;
   assign DEC_ADDR    = r_dec_addr;
   assign DEC_DI      = r_dec_di;
   assign SPI_MISO_OE = r_miso_oe;
   assign SPI_MISO    = r_miso_oe & r_miso_sr[31];
   assign BUSY        = (r_state != ST_IDLE) &&
                        !((r_state == ST_CMD) && (r_bit_cnt == 7'd0));

endmodule

// File: tb/tb_spi_opb_bridge.sv
// Directed bench for spi_opb_bridge: expected decoder transactions are queued
// as frames are driven and compared against strobes captured from the DUT.
module tb_spi_opb_bridge;

   localparam int SYNC = 2;
   localparam int HALF = 8;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] data;
   } txn_t;

   logic        clk;
   logic        rst;
   logic        sck;
   logic        cs_n;
   logic        mosi;
   logic        miso;
   logic        miso_oe;
   logic        dec_re;
   logic        dec_we;
   logic [31:0] dec_addr;
   logic [31:0] dec_di;
   logic [31:0] dec_do;
   logic        busy;

   logic [31:0] rd_val;
   txn_t        exp_q[$];
   txn_t        got_q[$];
   int          n_checks;
   int          n_err;
   int          oe_seen;
   int          busy_seen;
   int          miso_bad;
   int          both_strobes;
   logic [31:0] miso_word;

   spi_opb_bridge #(
      .SYNC_STAGES (SYNC),
      .CMD_RD      (8'h03),
      .CMD_WR      (8'h02)
   ) dut (
      .OPB_CLK     (clk),
      .OPB_RST     (rst),
      .SPI_SCK     (sck),
      .SPI_CS_N    (cs_n),
      .SPI_MOSI    (mosi),
      .SPI_MISO    (miso),
      .SPI_MISO_OE (miso_oe),
      .DEC_RE      (dec_re),
      .DEC_WE      (dec_we),
      .DEC_ADDR    (dec_addr),
      .DEC_DI      (dec_di),
      .DEC_DO      (dec_do),
      .BUSY        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // decoder model: read data valid only in the cycle after DEC_RE
   always @(posedge clk) dec_do <= dec_re ? rd_val : 32'h0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      txn_t t;
      @(posedge clk);
      #1;
      if (miso_oe) oe_seen++;
      if (busy) busy_seen++;
      if (!miso_oe && miso) miso_bad++;
      if (dec_re && dec_we) both_strobes++;
      if (dec_we) begin
         t.we = 1'b1; t.addr = dec_addr; t.data = dec_di;
         got_q.push_back(t);
      end
      if (dec_re) begin
         t.we = 1'b0; t.addr = dec_addr; t.data = 32'h0;
         got_q.push_back(t);
      end
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic spi_bits(input logic [79:0] v, input int from, input int to);
      for (int i = from; i < to; i++) begin
         mosi = v[79-i];
         ticks(HALF);
         if (i >= 48) miso_word = {miso_word[30:0], miso};
         sck = 1'b1;
         ticks(HALF);
         sck = 1'b0;
      end
   endtask

   task automatic push_exp(input logic we, input logic [31:0] a, input logic [31:0] d);
      txn_t t;
      t.we = we; t.addr = a; t.data = d;
      exp_q.push_back(t);
   endtask

   task automatic sb_check(input string tag);
      txn_t g;
      txn_t e;
      chk({tag, "_cnt"}, 64'(got_q.size()), 64'(exp_q.size()));
      while (got_q.size() > 0 && exp_q.size() > 0) begin
         g = got_q.pop_front();
         e = exp_q.pop_front();
         chk({tag, "_we"}, 64'(g.we), 64'(e.we));
         chk({tag, "_addr"}, 64'(g.addr), 64'(e.addr));
         if (e.we) chk({tag, "_data"}, 64'(g.data), 64'(e.data));
      end
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic frame_start();
      oe_seen = 0; busy_seen = 0; miso_word = 32'h0;
      cs_n = 1'b0;
      ticks(HALF);
   endtask

   task automatic frame_end();
      ticks(HALF);
      cs_n = 1'b1;
      ticks(2 * HALF);
   endtask

   initial begin
      n_checks = 0; n_err = 0; miso_bad = 0; both_strobes = 0;
      oe_seen = 0; busy_seen = 0; miso_word = 32'h0;
      rst = 1'b1; cs_n = 1'b1; sck = 1'b0; mosi = 1'b0; rd_val = 32'h0;

      // reset state
      ticks(4);
      chk("rst_ctrl", 64'({dec_re, dec_we, miso, miso_oe, busy}), 64'(5'b0));
      chk("rst_addr", 64'(dec_addr), 64'h0);
      chk("rst_di", 64'(dec_di), 64'h0);
      rst = 1'b0;
      ticks(6);
      got_q.delete();

      // single write
      push_exp(1'b1, 32'h0000_0104, 32'hDEAD_BEEF);
      frame_start();
      spi_bits({8'h02, 32'h0000_0104, 32'hDEAD_BEEF, 8'h00}, 0, 72);
      chk("wr_busy_seen", 64'(busy_seen > 0), 64'h1);
      frame_end();
      sb_check("wr1");
      chk("wr1_busy_idle", 64'(busy), 64'h0);
      chk("wr1_addr_hold", 64'(dec_addr), 64'h0000_0104);
      chk("wr1_di_hold", 64'(dec_di), 64'hDEAD_BEEF);

      // single read
      rd_val = 32'h1234_5678;
      push_exp(1'b0, 32'h0000_0010, 32'h0);
      frame_start();
      spi_bits({8'h03, 32'h0000_0010, 8'h00, 32'h0}, 0, 80);
      chk("rd1_oe_after80", 64'(miso_oe), 64'h0);
      chk("rd1_oe_seen", 64'(oe_seen > 0), 64'h1);
      chk("rd1_miso", 64'(miso_word), 64'h1234_5678);
      frame_end();
      sb_check("rd1");

      // abort after 20 bits, then a good write
      frame_start();
      spi_bits({8'h02, 32'hFFFF_0000, 32'h1111_2222, 8'h00}, 0, 20);
      cs_n = 1'b1;
      ticks(SYNC + 1);
      chk("abort_busy", 64'(busy), 64'h0);
      ticks(2 * HALF);
      sb_check("abort");
      chk("abort_addr_keep", 64'(dec_addr), 64'h0000_0010);
      push_exp(1'b1, 32'h55AA_0000, 32'h0BAD_F00D);
      frame_start();
      spi_bits({8'h02, 32'h55AA_0000, 32'h0BAD_F00D, 8'h00}, 0, 72);
      frame_end();
      sb_check("wr2");

      // unknown command, 72 clocks
      frame_start();
      spi_bits({8'hA5, 32'h0000_0200, 32'hFFFF_FFFF, 8'h00}, 0, 72);
      chk("bad_oe_seen", 64'(oe_seen), 64'h0);
      frame_end();
      sb_check("bad");

      // reset during the address phase of a read
      rd_val = 32'h7777_7777;
      frame_start();
      spi_bits({8'h03, 32'h0000_0300, 8'h00, 32'h0}, 0, 20);
      rst = 1'b1;
      ticks(3);
      chk("midrst_ctrl", 64'({dec_re, dec_we, miso, miso_oe, busy}), 64'(5'b0));
      chk("midrst_addr", 64'(dec_addr), 64'h0);
      chk("midrst_di", 64'(dec_di), 64'h0);
      rst = 1'b0;
      busy_seen = 0; oe_seen = 0;
      spi_bits({8'h03, 32'h0000_0300, 8'h00, 32'h0}, 20, 80);
      chk("midrst_busy_rest", 64'(busy_seen), 64'h0);
      chk("midrst_oe_rest", 64'(oe_seen), 64'h0);
      frame_end();
      sb_check("midrst");
      rd_val = 32'hCAFE_F00D;
      push_exp(1'b0, 32'h0000_0020, 32'h0);
      frame_start();
      spi_bits({8'h03, 32'h0000_0020, 8'h00, 32'h0}, 0, 80);
      chk("rd2_miso", 64'(miso_word), 64'hCAFE_F00D);
      frame_end();
      sb_check("rd2");

      // back-to-back write (with extra clocks) then read, 2 SCK periods apart
      push_exp(1'b1, 32'h0000_0200, 32'hA5A5_5A5A);
      frame_start();
      spi_bits({8'h02, 32'h0000_0200, 32'hA5A5_5A5A, 8'hFF}, 0, 80);
      ticks(HALF);
      cs_n = 1'b1;
      ticks(4 * HALF);
      rd_val = 32'h0F1E_2D3C;
      push_exp(1'b0, 32'h0000_0204, 32'h0);
      frame_start();
      spi_bits({8'h03, 32'h0000_0204, 8'h00, 32'h0}, 0, 80);
      chk("b2b_miso", 64'(miso_word), 64'h0F1E_2D3C);
      frame_end();
      sb_check("b2b");
      chk("b2b_di_hold", 64'(dec_di), 64'hA5A5_5A5A);

      chk("miso_low_when_off", 64'(miso_bad), 64'h0);
      chk("never_both_strobes", 64'(both_strobes), 64'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/spi_opb_bridge.md
SPI_OPB_BRIDGE -- requirements
Module: spi_opb_bridge

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchroniser depth for SPI_SCK, SPI_CS_N and SPI_MOSI.
REQ-002 Parameter CMD_RD, default 8'h03: read command code.
REQ-003 Parameter CMD_WR, default 8'h02: write command code.
REQ-004 OPB_CLK  input  1  sole clock; all logic on its rising edge.
REQ-005 OPB_RST  input  1  asynchronous, active-high reset.
REQ-006 SPI_SCK  input  1  SPI clock, mode 0, asynchronous to OPB_CLK, at most OPB_CLK/8.
REQ-007 SPI_CS_N  input  1  active-low frame select.
REQ-008 SPI_MOSI  input  1  serial data in, MSB first.
REQ-009 SPI_MISO  output  1  serial read data out, MSB first.
REQ-010 SPI_MISO_OE  output  1  high only while read data is being shifted out.
REQ-011 DEC_RE  output  1  one-cycle OPB read strobe to the address decoder.
REQ-012 DEC_WE  output  1  one-cycle OPB write strobe to the address decoder.
REQ-013 DEC_ADDR  output  32  OPB address.
REQ-014 DEC_DI  output  32  OPB write data.
REQ-015 DEC_DO  input  32  OPB read data, valid in the cycle after the DEC_RE cycle.
REQ-016 BUSY  output  1  high from the first command bit until the frame ends or is aborted.

Function
REQ-017 SCK, CS_N and MOSI SHALL pass through SYNC_STAGES flops; SCK rise and fall SHALL be detected as single-cycle pulses on the synchronised signal.
REQ-018 Frame format: 8-bit command, then 32-bit address. Write frames then carry 32 data bits. Read frames then carry 8 dummy bits followed by 32 data bits.
REQ-019 MOSI SHALL be sampled on each synchronised SCK rise while CS_N is low; a 7-bit bit counter SHALL track the position in the frame.
REQ-020 States: IDLE, CMD, ADDR, DUMMY, RDATA, WDATA, IGNORE.
  - CS_N falling edge: IDLE->CMD.
  - CMD->ADDR after 8 bits if the command equals CMD_RD or CMD_WR; otherwise CMD->IGNORE.
  - ADDR->DUMMY (read) or ADDR->WDATA (write) after bit 40.
  - DUMMY->RDATA after bit 48.
  - WDATA->IGNORE after bit 72.
  - RDATA->IGNORE after bit 80.
REQ-021 CS_N high in any state SHALL return the FSM to IDLE in the next cycle without issuing any further strobe.
REQ-022 DEC_ADDR SHALL load on the cycle after bit 40 is sampled. DEC_DI SHALL load on the cycle after bit 72 is sampled. Both SHALL hold until reloaded by a later frame.
REQ-023 Write: DEC_WE SHALL be high for exactly one cycle, the cycle after bit 72 is sampled, with DEC_ADDR and DEC_DI already valid.
REQ-024 Read: DEC_RE SHALL be high for exactly one cycle, the cycle after bit 40 is sampled.
REQ-025 Read data: an internal 32-bit register SHALL load DEC_DO at the clock edge ending the cycle after the DEC_RE cycle.
REQ-026 Read shift-out:
  - On the SCK fall following bit 48, SPI_MISO SHALL present read-data bit 31 and SPI_MISO_OE SHALL assert.
  - Each subsequent SCK fall SHALL shift out the next bit.
  - SPI_MISO_OE SHALL deassert on CS_N high or after bit 80.
REQ-027 SPI_MISO SHALL be 0 whenever SPI_MISO_OE is low.
REQ-028 Extra SCK edges beyond the frame length SHALL be ignored (IGNORE state) until CS_N rises.
REQ-029 DEC_RE and DEC_WE SHALL never be high in the same cycle; at most one strobe SHALL be issued per frame.

Reset
REQ-030 While OPB_RST is high:
  - FSM SHALL be in IDLE.
  - DEC_RE, DEC_WE, SPI_MISO, SPI_MISO_OE and BUSY SHALL be 0.
  - DEC_ADDR and DEC_DI SHALL be 32'h0.
  - Synchroniser flops SHALL hold the idle levels: CS_N=1, SCK=0.
REQ-031 After a reset mid-frame, the bridge SHALL ignore the rest of that frame and accept a new frame only after a fresh CS_N falling edge.

Structure
REQ-032 Shared package spi_opb_pkg SHALL hold:
  - state encoding;
  - default command codes;
  - frame bit-boundary constants (8, 40, 48, 72, 80).
REQ-033 One sub-module, spi_in_sync, SHALL implement the synchronisers and SCK/CS_N edge detection.

Verification
REQ-034 Write frame 0x02, 0x00000104, 0xDEADBEEF -> exactly one DEC_WE pulse with DEC_ADDR=0x00000104 and DEC_DI=0xDEADBEEF; no DEC_RE pulse.
REQ-035 Read frame 0x03, 0x00000010 with the decoder model returning 0x12345678 one cycle after DEC_RE -> one DEC_RE pulse with DEC_ADDR=0x00000010; MISO shifts out 0x12345678 during bits 49-80.
REQ-036 CS_N raised after 20 bits -> no strobe, BUSY=0 within 1 cycle + synchroniser delay; a following write frame completes correctly.
REQ-037 Command 0xA5 with 72 SCKs -> no strobe; SPI_MISO_OE stays 0 throughout.
REQ-038 OPB_RST pulsed during ADDR of a read frame -> all outputs return to reset values; no DEC_RE for that frame; the next frame is accepted.
REQ-039 Back-to-back write then read with CS_N high for 2 SCK periods between frames -> both strobes issue once each with correct address and data.
